// File: rtl/pipe_rca.sv
// pipe_rca: pipelined ripple-carry adder/subtractor with a valid/ready handshake.
//
// The WIDTH-bit operands are split into STAGES chunks of CW = WIDTH/STAGES bits.
// Stage k adds chunk k, using the carry registered by stage k-1. Stage 0 uses c0.
// Operand chunks that are not yet consumed travel through skew registers.
// Result chunks that are already finished travel through de-skew registers.
// As a result, every output bit of a result comes from the same operation.
// Latency is STAGES cycles and throughput is one operation per cycle.
// A single advance signal stalls the whole pipeline while a result waits for
// the consumer.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   cin        in   1      carry in (add) / borrow in (sub)
//   sub        in   1      0: A+B+cin ; 1: A-B-cin
//   in_valid   in   1      operand set valid
//   in_ready   out  1      operands accepted this cycle
//   sum        out  WIDTH  result (mod 2^WIDTH)
//   cout       out  1      carry out of MSB (sub mode: 1 = no borrow)
//   ovf        out  1      two's-complement signed overflow
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts the result this cycle
module pipe_rca #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CW = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_rca: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Element k of each link array holds the value that enters stage k.
    // The last element of s_link, c_link and v_link drives the outputs.
    logic [WIDTH-1:0] a_link [0:STAGES-1];
    logic [WIDTH-1:0] b_link [0:STAGES-1];
    logic [WIDTH-1:0] s_link [0:STAGES];
    logic [STAGES:0]  c_link;
    logic [STAGES:0]  v_link;

    // Subtraction is A + ~B + ~cin, so the borrow-in becomes an inverted carry.
    assign b_eff = sub ? ~B : B;
    assign c0    = sub ? ~cin : cin;

    assign advance  = !v_link[STAGES] || out_ready;
    assign in_ready = advance;

    assign a_link[0] = A;
    assign b_link[0] = b_eff;
    assign s_link[0] = '0;
    assign c_link[0] = c0;
    assign v_link[0] = in_valid;

    assign sum       = s_link[STAGES];
    assign cout      = c_link[STAGES];
    assign out_valid = v_link[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0]      part;
        logic [WIDTH-1:0] s_next;
        logic [WIDTH-1:0] s_r;
        logic             c_r;
        logic             v_r;

        always_comb begin
            part = {1'b0, a_link[k][k*CW +: CW]}
                 + {1'b0, b_link[k][k*CW +: CW]}
                 + {{CW{1'b0}}, c_link[k]};
            s_next = s_link[k];
            s_next[k*CW +: CW] = part[CW-1:0];
        end

        // A bubble leaves the data registers untouched.
        // The outputs therefore keep showing the last real result.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
                s_r <= '0;
                c_r <= 1'b0;
            end else if (advance) begin
                v_r <= v_link[k];
                if (v_link[k]) begin
                    s_r <= s_next;
                    c_r <= part[CW];
                end
            end
        end

        assign s_link[k+1] = s_r;
        assign c_link[k+1] = c_r;
        assign v_link[k+1] = v_r;

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance && v_link[k]) begin
                    a_r <= a_link[k];
                    b_r <= b_link[k];
                end
            end

            assign a_link[k+1] = a_r;
            assign b_link[k+1] = b_r;
        end else begin : g_last
            // The MSB chunk is added here, so overflow is known in the same cycle.
            logic ovf_next;
            logic ovf_r;

            always_comb begin
                ovf_next = (a_link[k][WIDTH-1] == b_link[k][WIDTH-1])
                        && (s_next[WIDTH-1] != a_link[k][WIDTH-1]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (advance && v_link[k]) begin
                    ovf_r <= ovf_next;
                end
            end

            assign ovf = ovf_r;
        end
    end

endmodule
